// File: rtl/alu_exec_wb.sv
// Two-stage execute/write-back pipeline: EX latches operands, WB drives the
// register-file write port, status flags and retirement/overflow counters.
module alu_exec_wb #(
   parameter int CNT_W     = 16,
   parameter int OVF_CNT_W = 8
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 InValid,
   input  logic                 Stall,
   input  logic [31:0]          A,
   input  logic [31:0]          B,
   input  logic [5:0]           OpCode,
   input  logic [4:0]           WriteRegIn,
   output logic                 RegWrite,
   output logic [4:0]           WriteReg,
   output logic [31:0]          WriteData,
   output logic                 OutValid,
   output logic                 Zero,
   output logic                 Overflow,
   output logic                 Illegal,
   output logic [CNT_W-1:0]     RetireCount,
   output logic [OVF_CNT_W-1:0] OvfCount
);

   localparam logic [5:0] OP_AND = 6'b000000;
   localparam logic [5:0] OP_OR  = 6'b000001;
   localparam logic [5:0] OP_ADD = 6'b000010;
   localparam logic [5:0] OP_SUB = 6'b000110;
   localparam logic [5:0] OP_SLT = 6'b000111;
   localparam logic [5:0] OP_NOR = 6'b001100;

   logic        ex_valid;
   logic [31:0] ex_a, ex_b;
   logic [5:0]  ex_op;
   logic [4:0]  ex_rd;

   logic [31:0] sum, diff, alu_res;
   logic        alu_ovf, alu_ill;

   assign sum  = ex_a + ex_b;
   assign diff = ex_a - ex_b;

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      alu_ill = 1'b0;
      case (ex_op)
         OP_AND: alu_res = ex_a & ex_b;
         OP_OR:  alu_res = ex_a | ex_b;
         OP_ADD: begin
            alu_res = sum;
            alu_ovf = (ex_a[31] == ex_b[31]) && (sum[31] != ex_a[31]);
         end
         OP_SUB: begin
            alu_res = diff;
            alu_ovf = (ex_a[31] != ex_b[31]) && (diff[31] != ex_a[31]);
         end
         OP_SLT: alu_res = ($signed(ex_a) < $signed(ex_b)) ? 32'd1 : 32'd0;
         OP_NOR: alu_res = ~(ex_a | ex_b);
         default: alu_ill = 1'b1;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         ex_valid    <= 1'b0;
         ex_a        <= '0;
         ex_b        <= '0;
         ex_op       <= '0;
         ex_rd       <= '0;
         OutValid    <= 1'b0;
         RegWrite    <= 1'b0;
         WriteReg    <= '0;
         WriteData   <= '0;
         Zero        <= 1'b0;
         Overflow    <= 1'b0;
         Illegal     <= 1'b0;
         RetireCount <= '0;
         OvfCount    <= '0;
      end else if (!Stall) begin
         ex_valid  <= InValid;
         ex_a      <= A;
         ex_b      <= B;
         ex_op     <= OpCode;
         ex_rd     <= WriteRegIn;
         OutValid  <= ex_valid;
         WriteData <= ex_valid ? alu_res : '0;
         WriteReg  <= ex_valid ? ex_rd : '0;
         Zero      <= ex_valid && (alu_res == '0);
         Overflow  <= ex_valid && alu_ovf;
         Illegal   <= ex_valid && alu_ill;
         RegWrite  <= ex_valid && !alu_ovf && !alu_ill && (ex_rd != '0);
         if (ex_valid)
            RetireCount <= RetireCount + CNT_W'(1);
         if (ex_valid && alu_ovf && (OvfCount != '1))
            OvfCount <= OvfCount + OVF_CNT_W'(1);
      end else begin
         // Held instruction keeps its data, but the write strobe is one pulse only.
         RegWrite <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_exec_wb.sv
// Scoreboard bench for alu_exec_wb: expectations queued at issue, checked as
// each instruction lands in write-back.
module tb_alu_exec_wb;

   localparam int CW = 6;
   localparam int OW = 3;

   logic          CLK = 1'b0;
   logic          RESET, InValid, Stall;
   logic [31:0]   A, B;
   logic [5:0]    OpCode;
   logic [4:0]    WriteRegIn;
   logic          RegWrite, OutValid, Zero, Overflow, Illegal;
   logic [4:0]    WriteReg;
   logic [31:0]   WriteData;
   logic [CW-1:0] RetireCount;
   logic [OW-1:0] OvfCount;

   alu_exec_wb #(.CNT_W(CW), .OVF_CNT_W(OW)) dut (
      .CLK(CLK), .RESET(RESET), .InValid(InValid), .Stall(Stall),
      .A(A), .B(B), .OpCode(OpCode), .WriteRegIn(WriteRegIn),
      .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
      .OutValid(OutValid), .Zero(Zero), .Overflow(Overflow), .Illegal(Illegal),
      .RetireCount(RetireCount), .OvfCount(OvfCount)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] res;
      logic        ovf;
      logic        ill;
      logic [4:0]  rd;
   } exp_t;

   exp_t          q[$];
   exp_t          last;
   int            n_chk = 0;
   int            n_fail = 0;
   logic [CW-1:0] exp_ret = '0;
   logic [OW-1:0] exp_ovf = '0;
   logic          last_stall = 1'b0;
   logic          last_rst = 1'b0;
   logic          mon_en = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [5:0] op, input logic [4:0] rd);
      exp_t e;
      e.res = '0; e.ovf = 1'b0; e.ill = 1'b0; e.rd = rd;
      case (op)
         6'b000000: e.res = a & b;
         6'b000001: e.res = a | b;
         6'b000010: begin
            e.res = a + b;
            e.ovf = (a[31] == b[31]) && (e.res[31] != a[31]);
         end
         6'b000110: begin
            e.res = a - b;
            e.ovf = (a[31] != b[31]) && (e.res[31] != a[31]);
         end
         // differing signs: the negative one is smaller; same sign: unsigned order
         6'b000111: e.res = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
         6'b001100: e.res = ~(a | b);
         default:   e.ill = 1'b1;
      endcase
      return e;
   endfunction

   always @(posedge CLK) begin
      last_stall = Stall;
      last_rst   = RESET;
      if (RESET) begin
         q.delete();
         exp_ret = '0;
         exp_ovf = '0;
      end
   end

   always @(negedge CLK) begin
      if (mon_en) begin
         if (last_rst) begin
            chk("rst_valid", {31'd0, OutValid}, 32'd0);
            chk("rst_data", WriteData, 32'd0);
            chk("rst_reg", {27'd0, WriteReg}, 32'd0);
         end
         if (!OutValid) begin
            chk("bubble_wr", {31'd0, RegWrite}, 32'd0);
            chk("bubble_flags", {29'd0, Zero, Overflow, Illegal}, 32'd0);
         end else if (!last_stall) begin
            if (q.size() == 0) begin
               chk("sb_underflow", 32'd1, 32'd0);
            end else begin
               last = q.pop_front();
               exp_ret = exp_ret + 1'b1;
               if (last.ovf && exp_ovf != {OW{1'b1}}) exp_ovf = exp_ovf + 1'b1;
               chk("wb_data", WriteData, last.res);
               chk("wb_reg", {27'd0, WriteReg}, {27'd0, last.rd});
               chk("wb_ovf", {31'd0, Overflow}, {31'd0, last.ovf});
               chk("wb_ill", {31'd0, Illegal}, {31'd0, last.ill});
               chk("wb_zero", {31'd0, Zero}, {31'd0, (last.res == 32'd0)});
               chk("wb_regwrite", {31'd0, RegWrite},
                   {31'd0, (!last.ovf && !last.ill && last.rd != 5'd0)});
            end
         end else begin
            chk("stall_wr", {31'd0, RegWrite}, 32'd0);
            chk("stall_data", WriteData, last.res);
            chk("stall_ovf", {31'd0, Overflow}, {31'd0, last.ovf});
         end
         chk("retire_cnt", {26'd0, RetireCount}, {26'd0, exp_ret});
         chk("ovf_cnt", {29'd0, OvfCount}, {29'd0, exp_ovf});
      end
   end

   task automatic issue(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] op, input logic [4:0] rd);
      InValid = v; A = a; B = b; OpCode = op; WriteRegIn = rd; Stall = 1'b0;
      if (v) q.push_back(model(a, b, op, rd));
      @(posedge CLK); #1;
   endtask

   task automatic bubble(input int n);
      repeat (n) issue(1'b0, $urandom, $urandom, 6'b000010, 5'd1);
   endtask

   // Inputs during a stall are garbage; they must be dropped.
   task automatic stall_n(input int n);
      Stall = 1'b1;
      repeat (n) begin
         InValid = 1'b1; A = $urandom; B = $urandom;
         OpCode = 6'b000010; WriteRegIn = 5'd31;
         @(posedge CLK); #1;
      end
      Stall = 1'b0; InValid = 1'b0;
   endtask

   logic [5:0] ops [7] = '{6'b000000, 6'b000001, 6'b000010, 6'b000110,
                           6'b000111, 6'b001100, 6'b111111};

   initial begin
      RESET = 1'b1; InValid = 1'b0; Stall = 1'b0;
      A = '0; B = '0; OpCode = '0; WriteRegIn = '0;
      repeat (2) @(posedge CLK);
      #1;
      mon_en = 1'b1;
      RESET = 1'b0;

      issue(1'b1, 32'd5, 32'd7, 6'b000010, 5'd2);
      issue(1'b1, 32'h7FFF_FFFF, 32'd1, 6'b000010, 5'd3);
      issue(1'b1, 32'h8000_0000, 32'd1, 6'b000110, 5'd4);
      issue(1'b1, 32'hFFFF_FFFF, 32'd1, 6'b000111, 5'd5);
      issue(1'b1, 32'd1, 32'hFFFF_FFFF, 6'b000111, 5'd6);
      issue(1'b1, 32'd0, 32'd0, 6'b001100, 5'd7);
      issue(1'b1, 32'hFFFF_0000, 32'h0F0F_0F0F, 6'b000000, 5'd0);
      issue(1'b1, 32'd9, 32'd9, 6'b111111, 5'd8);
      issue(1'b1, 32'hF0, 32'h0F, 6'b000001, 5'd9);
      bubble(1);
      stall_n(3);
      bubble(2);
      issue(1'b1, 32'd1, 32'd2, 6'b000010, 5'd10);
      issue(1'b1, 32'd3, 32'd4, 6'b000010, 5'd10);
      bubble(2);

      // overflow counter saturation
      for (int i = 0; i < 9; i++)
         issue(1'b1, 32'h4000_0000 + i, 32'h4000_0000, 6'b000010, 5'd11);
      bubble(2);

      // random mix; carries RetireCount past its wrap point
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 7) == 0) stall_n($urandom_range(1, 3));
         if ($urandom_range(0, 5) == 0) bubble(1);
         else issue(1'b1, $urandom, ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom,
                    ops[$urandom_range(0, 6)], 5'($urandom_range(0, 31)));
      end
      bubble(2);

      // reset with instructions in flight and a valid bundle on the inputs
      issue(1'b1, 32'd20, 32'd22, 6'b000010, 5'd12);
      RESET = 1'b1; InValid = 1'b1; A = 32'd1; B = 32'd1; OpCode = 6'b000010; WriteRegIn = 5'd13;
      @(posedge CLK); #1;
      RESET = 1'b0;
      bubble(3);
      issue(1'b1, 32'd100, 32'd1, 6'b000110, 5'd14);
      bubble(3);

      chk("sb_empty", q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
